// File: rtl/rom_stream_reader.sv
// Streams a contiguous, wrapping address range out of a 1-cycle-latency ROM
// as a valid/ready stream, using a 2-entry buffer to absorb backpressure.
module rom_stream_reader #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] start_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_en,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);
    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned LW = ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_issued;
    logic          r_inflight;
    logic          r_inflight_last;
    logic [DW-1:0] r_fifo_data [2];
    logic [1:0]    r_fifo_last;
    logic          r_wr;
    logic          r_rd;
    logic [1:0]    r_count;
    logic          r_busy;
    logic          r_done;

    logic          w_pop;
    logic          w_issue;
    logic          w_issue_last;
    logic [2:0]    w_occ;

    // A read may issue only if its word is guaranteed a FIFO slot on arrival.
    assign w_pop        = (r_count != 2'd0) && m_ready;
    assign w_occ        = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue      = (r_state == S_RUN) && (r_issued < r_len) && (w_occ < 3'd2);
    assign w_issue_last = (r_issued == (r_len - LW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_len           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= '0;
            r_wr            <= 1'b0;
            r_rd            <= 1'b0;
            r_count         <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;

            if (w_issue) begin
                r_ptr    <= r_ptr + AW'(1);
                r_issued <= r_issued + LW'(1);
            end

            // ROM output is only meaningful the cycle after a read was issued.
            if (r_inflight) begin
                r_fifo_data[r_wr] <= rom_dout;
                r_fifo_last[r_wr] <= r_inflight_last;
                r_wr              <= ~r_wr;
            end

            if (w_pop) begin
                r_rd <= ~r_rd;
            end

            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            r_busy   <= 1'b1;
                            r_ptr    <= start_addr;
                            r_len    <= length;
                            r_issued <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue && w_issue_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && r_fifo_last[r_rd]) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rom_en   = w_issue;
    assign rom_addr = r_ptr;
    assign m_valid  = (r_count != 2'd0);
    assign m_data   = r_fifo_data[r_rd];
    assign m_last   = m_valid && r_fifo_last[r_rd];

endmodule
